// File: rtl/pixel_write_arbiter_pkg.sv
// pixel_write_arbiter_pkg: frame geometry, coordinate types and FSM states shared by the arbiter slice
package pixel_write_arbiter_pkg;
  localparam int h_size = 640;
  localparam int v_line = 480;
  localparam int color_depth = 8;
  localparam int hw = $clog2(h_size);
  localparam int vw = $clog2(v_line);
  typedef logic [hw-1:0] h_t;
  typedef logic [vw-1:0] v_t;
  typedef logic [color_depth-1:0] c_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;
  function automatic h_t clamp_h(h_t x);
    return x > h_t'(h_size - 1) ? h_t'(h_size - 1) : x;
  endfunction
  function automatic v_t clamp_v(v_t x);
    return x > v_t'(v_line - 1) ? v_t'(v_line - 1) : x;
  endfunction
endpackage

// File: rtl/pixel_write_arbiter_if.sv
// pixel_write_arbiter_if: host port, fill command port and pixel_memory write port
interface pixel_write_arbiter_if;
  import pixel_write_arbiter_pkg::*;
  logic host_req;
  h_t host_h;
  v_t host_v;
  c_t host_color;
  logic host_ack;
  logic fill_start;
  h_t fill_h0;
  h_t fill_h1;
  v_t fill_v0;
  v_t fill_v1;
  c_t fill_color;
  logic fill_busy;
  logic fill_done;
  logic write_en;
  h_t h_pixel_write;
  v_t v_pixel_write;
  c_t color_write;
  modport master (
    output host_req, host_h, host_v, host_color, fill_start, fill_h0, fill_h1, fill_v0, fill_v1, fill_color,
    input host_ack, fill_busy, fill_done, write_en, h_pixel_write, v_pixel_write, color_write
  );
  modport slave (
    input host_req, host_h, host_v, host_color, fill_start, fill_h0, fill_h1, fill_v0, fill_v1, fill_color,
    output host_ack, fill_busy, fill_done, write_en, h_pixel_write, v_pixel_write, color_write
  );
endinterface

// File: rtl/pixel_write_arbiter_rect_scanner.sv
// pixel_write_arbiter_rect_scanner: row-major cursor over a clamped rectangle
module pixel_write_arbiter_rect_scanner
  import pixel_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  input  h_t   h0,
  input  h_t   h1,
  input  v_t   v0,
  input  v_t   v1,
  output h_t   h,
  output v_t   v,
  output logic last
);
  h_t h0_q, h1_q;
  v_t v1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q <= '0;
      h1_q <= '0;
      v1_q <= '0;
      h <= '0;
      v <= '0;
    end else if (load) begin
      h0_q <= h0;
      h1_q <= h1;
      v1_q <= v1;
      h <= h0;
      v <= v0;
    end else if (step) begin
      h <= h == h1_q ? h0_q : h + h_t'(1);
      v <= h == h1_q ? v + v_t'(1) : v;
    end
  end
  assign last = h == h1_q && v == v1_q;
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin owner of the pixel_memory write port shared by
// the host single-pixel port and the rectangle-fill engine
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
(
  input logic clk,
  input logic reset,
  pixel_write_arbiter_if.slave bus
);
  state_t state, state_nx;
  logic rr_host, accept, empty, fill_req, host_gnt, fill_gnt, last;
  h_t h1c, sh;
  v_t v1c, sv;
  c_t fill_color_q;
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == ST_IDLE ? (accept && !empty ? ST_FILL : ST_IDLE)
                                : (fill_gnt && last ? ST_IDLE : ST_FILL);
  end
  // h0/v0 beyond the frame fall out as empty because the clamped h1/v1 are always in range
  always_comb begin
    h1c = clamp_h(bus.fill_h1);
    v1c = clamp_v(bus.fill_v1);
    accept = bus.fill_start && state == ST_IDLE;
    empty = bus.fill_h0 > h1c || bus.fill_v0 > v1c;
    fill_req = state == ST_FILL;
    host_gnt = bus.host_req && (!fill_req || rr_host);
    fill_gnt = fill_req && !host_gnt;
  end
  pixel_write_arbiter_rect_scanner u_scan (
    .clk(clk),
    .reset(reset),
    .load(accept && !empty),
    .step(fill_gnt),
    .h0(bus.fill_h0),
    .h1(h1c),
    .v0(bus.fill_v0),
    .v1(v1c),
    .h(sh),
    .v(sv),
    .last(last)
  );
  assign bus.host_ack = host_gnt;
  assign bus.fill_busy = state == ST_FILL;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_host <= 1'b1;
      fill_color_q <= '0;
      bus.write_en <= 1'b0;
      bus.fill_done <= 1'b0;
      bus.h_pixel_write <= '0;
      bus.v_pixel_write <= '0;
      bus.color_write <= '0;
    end else begin
      bus.write_en <= host_gnt || fill_gnt;
      bus.fill_done <= (fill_gnt && last) || (accept && empty);
      if (accept) fill_color_q <= bus.fill_color;
      if (host_gnt || fill_gnt) begin
        rr_host <= fill_gnt;
        bus.h_pixel_write <= host_gnt ? bus.host_h : sh;
        bus.v_pixel_write <= host_gnt ? bus.host_v : sv;
        bus.color_write <= host_gnt ? bus.host_color : fill_color_q;
      end
    end
  end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: directed and random stimulus against a pixel-queue reference model
module tb_pixel_write_arbiter;
  import pixel_write_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  pixel_write_arbiter_if bus ();
  pixel_write_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0, checks = 0;
  int pq_h[$], pq_v[$];
  int m_color = 0;
  bit m_pref_host = 1;
  bit m_hg;
  int e_we, e_h, e_v, e_c, e_done, e_busy;
  int wlog_h[$], wlog_v[$];
  bit hp = 0;
  int hh, hv, hc, acks;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs();
    check("write_en", bus.write_en, e_we);
    check("h_pixel_write", bus.h_pixel_write, e_h);
    check("v_pixel_write", bus.v_pixel_write, e_v);
    check("color_write", bus.color_write, e_c);
    check("fill_done", bus.fill_done, e_done);
    check("fill_busy", bus.fill_busy, e_busy);
  endtask
  task automatic do_reset();
    reset = 1;
    bus.host_req = 0; bus.host_h = 0; bus.host_v = 0; bus.host_color = 0;
    bus.fill_start = 0; bus.fill_h0 = 0; bus.fill_h1 = 0; bus.fill_v0 = 0; bus.fill_v1 = 0; bus.fill_color = 0;
    @(posedge clk); @(negedge clk);
    reset = 0;
    pq_h.delete(); pq_v.delete();
    m_pref_host = 1; hp = 0;
    {e_we, e_h, e_v, e_c, e_done, e_busy} = '0;
    check_outs();
    check("host_ack_reset", bus.host_ack, 0);
  endtask
  task automatic step(int hreq, int h, int v, int c, int fs, int h0, int h1, int v0, int v1, int fc);
    bit fr, fg;
    int ch1, cv1;
    bus.host_req = hreq[0]; bus.host_h = h_t'(h); bus.host_v = v_t'(v); bus.host_color = c_t'(c);
    bus.fill_start = fs[0]; bus.fill_h0 = h_t'(h0); bus.fill_h1 = h_t'(h1);
    bus.fill_v0 = v_t'(v0); bus.fill_v1 = v_t'(v1); bus.fill_color = c_t'(fc);
    #1;
    fr = pq_h.size() > 0;
    m_hg = hreq != 0 && (!fr || m_pref_host);
    fg = fr && !m_hg;
    check("host_ack", bus.host_ack, m_hg);
    e_we = m_hg || fg;
    e_done = 0;
    if (m_hg) begin e_h = h; e_v = v; e_c = c; end
    if (fg) begin
      e_h = pq_h.pop_front(); e_v = pq_v.pop_front(); e_c = m_color;
      e_done = pq_h.size() == 0;
    end
    if (m_hg || fg) m_pref_host = fg;
    if (fs != 0 && !fr) begin
      ch1 = h1 > h_size - 1 ? h_size - 1 : h1;
      cv1 = v1 > v_line - 1 ? v_line - 1 : v1;
      if (h0 > ch1 || v0 > cv1) e_done = 1;
      else begin
        for (int y = v0; y <= cv1; y++)
          for (int x = h0; x <= ch1; x++) begin pq_h.push_back(x); pq_v.push_back(y); end
        m_color = fc;
      end
    end
    e_busy = pq_h.size() > 0;
    @(posedge clk); @(negedge clk);
    check_outs();
    if (bus.write_en) begin wlog_h.push_back(int'(bus.h_pixel_write)); wlog_v.push_back(int'(bus.v_pixel_write)); end
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic host_step(int fs, int h0, int h1, int v0, int v1, int fc, bit want);
    if (!hp && want) begin
      hp = 1; hh = $urandom_range(0, h_size - 1); hv = $urandom_range(0, v_line - 1); hc = $urandom_range(0, 255);
    end
    step(hp, hh, hv, hc, fs, h0, h1, v0, v1, fc);
    if (m_hg) begin hp = 0; acks++; end
  endtask
  initial begin
    int exp_h[6] = '{2, 3, 4, 2, 3, 4};
    int exp_v[6] = '{1, 1, 1, 2, 2, 2};
    do_reset();
    step(1, 3, 5, 'hA5, 0, 0, 0, 0, 0, 0);
    check("t1_h", bus.h_pixel_write, 3);
    check("t1_color", bus.color_write, 'hA5);
    idle(2);
    wlog_h.delete(); wlog_v.delete();
    step(0, 0, 0, 0, 1, 2, 4, 1, 2, 'h3C);
    idle(7);
    check("t2_writes", wlog_h.size(), 6);
    for (int i = 0; i < 6 && i < wlog_h.size(); i++) begin
      check("t2_h", wlog_h[i], exp_h[i]);
      check("t2_v", wlog_v[i], exp_v[i]);
    end
    wlog_h.delete(); wlog_v.delete(); acks = 0;
    step(0, 0, 0, 0, 1, 10, 13, 7, 7, 'h11);
    for (int i = 0; i < 8; i++) host_step(0, 0, 0, 0, 0, 0, acks + int'(hp) < 4);
    check("t3_writes", wlog_h.size(), 8);
    check("t3_acks", acks, 4);
    idle(2);
    wlog_h.delete(); wlog_v.delete();
    step(0, 0, 0, 0, 1, 638, 1000, 479, 511, 'h77);
    idle(3);
    check("t4_clamp_writes", wlog_h.size(), 2);
    step(0, 0, 0, 0, 1, 5, 2, 0, 0, 'h12);
    step(0, 0, 0, 0, 1, 700, 800, 0, 0, 'h12);
    step(0, 0, 0, 0, 1, 0, 3, 490, 500, 'h12);
    idle(1);
    step(0, 0, 0, 0, 1, 100, 109, 50, 59, 'h55);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h99);
    idle(2);
    do_reset();
    idle(3);
    wlog_h.delete(); wlog_v.delete();
    for (int i = 0; i < 3; i++) step(1, 20 + i, 30 + i, 'h40 + i, 0, 0, 0, 0, 0, 0);
    check("t6_writes", wlog_h.size(), 3);
    check("t6_last_h", bus.h_pixel_write, 22);
    for (int i = 0; i < 3000; i++) begin
      int h0 = $urandom_range(0, 660);
      int v0 = $urandom_range(0, 490);
      int h1 = h0 + $urandom_range(0, 4) - 1;
      int v1 = v0 + $urandom_range(0, 3) - 1;
      if (h1 > 1023) h1 = 1023;
      if (v1 > 511) v1 = 511;
      if (h1 < 0) h1 = 0;
      if (v1 < 0) v1 = 0;
      if ($urandom_range(0, 299) == 0) do_reset();
      else host_step($urandom_range(0, 7) == 0, h0, h1, v0, v1, $urandom_range(0, 255), $urandom_range(0, 1) == 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
